spi2mem_slave: RTL

SPI2MEM_SLAVE -- requirements
Module: spi2mem_slave

---
 rtl/spi2mem_slave_pkg.sv | 28 ++
 rtl/spi2mem_slave_if.sv | 16 +
 rtl/spi2mem_slave_sync_ff.sv | 35 +++
 rtl/spi2mem_slave.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/spi2mem_slave_pkg.sv
// -----------------------------------------------------------------------------
// spi_slave_pkg
// Shared definitions for the SPI-to-memory slave:
//   state_t      : frame FSM state encodings (IDLE, SHIFT, CHECK)
//   SYNC_DEPTH   : number of flops in each asynchronous-input synchronizer
//   edge_t       : SPI clock edge selector
//   SAMPLE_EDGE  : edge on which MOSI is captured (mode 0: rising)
//   SHIFT_EDGE   : edge on which the master changes MOSI (mode 0: falling)
// -----------------------------------------------------------------------------
package spi_slave_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_CHECK = 2'd2
  } state_t;

  localparam int SYNC_DEPTH = 2;

  typedef enum logic {
    EDGE_RISE = 1'b0,
    EDGE_FALL = 1'b1
  } edge_t;

  localparam edge_t SAMPLE_EDGE = EDGE_RISE;
  localparam edge_t SHIFT_EDGE  = EDGE_FALL;

endpackage

// File: rtl/spi2mem_slave_if.sv
// -----------------------------------------------------------------------------
// spi2mem_slave_if
// SPI bus bundle between an SPI master and spi2mem_slave.
//   spi_clk : serial clock (mode 0)
//   cs_n    : active-low chip select
//   mosi    : serial data, MSB first
// Modports: master drives the bus, slave receives it.
// -----------------------------------------------------------------------------
interface spi2mem_slave_if;
  logic spi_clk;
  logic cs_n;
  logic mosi;

  modport master (output spi_clk, output cs_n, output mosi);
  modport slave  (input  spi_clk, input  cs_n, input  mosi);
endinterface

// File: rtl/spi2mem_slave_sync_ff.sv
// -----------------------------------------------------------------------------
// sync_ff
// Multi-flop synchronizer for one asynchronous single-bit input.
// Parameters:
//   DEPTH   : number of flops in the chain (>= 2)
//   RST_VAL : value loaded into every flop while reset_n is low
// Ports:
//   clk     : system clock
//   reset_n : synchronous active-low reset
//   i_d     : asynchronous input
//   o_q     : synchronized output
// -----------------------------------------------------------------------------
module sync_ff #(
  parameter int   DEPTH   = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_d,
  output logic o_q
);

  logic [DEPTH-1:0] r_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_q <= {DEPTH{RST_VAL}};
    end else begin
      r_q <= {r_q[DEPTH-2:0], i_d};
    end
  end

  assign o_q = r_q[DEPTH-1];

endmodule

// File: rtl/spi2mem_slave.sv
// -----------------------------------------------------------------------------
// spi2mem_slave
// SPI mode-0 slave that receives a fixed-length frame and, if the frame is
// well formed, loads its payload into a registered output word.
//
// Parameters:
//   WIDTH       : payload bits per frame and width of memory
//   RESET_VALUE : memory contents after reset
// Ports:
//   clk       : system clock (all logic on rising edge)
//   reset_n   : synchronous active-low reset
//   spi       : SPI bus (spi2mem_slave_if.slave: spi_clk, cs_n, mosi)
//   memory    : last accepted payload word
//   update    : one-clk pulse when memory is loaded
//   frame_err : one-clk pulse when a frame is rejected
//   busy      : high while a frame is being shifted in
//
// Build option: define SPI2MEM_SLAVE_PARITY_EN to append an odd-parity bit
// to each frame (WIDTH+1 bits); a parity mismatch rejects the frame.
// -----------------------------------------------------------------------------
module spi2mem_slave
  import spi_slave_pkg::*;
#(
  parameter int               WIDTH       = 48,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  spi2mem_slave_if.slave   spi,
  output logic [WIDTH-1:0] memory,
  output logic             update,
  output logic             frame_err,
  output logic             busy
);

`ifdef SPI2MEM_SLAVE_PARITY_EN
  localparam int FRAME_BITS = WIDTH + 1;
`else
  localparam int FRAME_BITS = WIDTH;
`endif

  // Counter must hold FRAME_BITS+1 so over-length frames stay distinguishable.
  localparam int                CNT_W    = $clog2(FRAME_BITS + 2);
  localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(FRAME_BITS);
  localparam logic [CNT_W-1:0]  CNT_SAT  = CNT_W'(FRAME_BITS + 1);

  // Cycles after reset before the synchronized cs_n reflects the pin.
  localparam int                SETTLE      = SYNC_DEPTH + 1;
  localparam int                SETTLE_W    = $clog2(SETTLE + 1);
  localparam logic [SETTLE_W-1:0] SETTLE_DONE = SETTLE_W'(SETTLE);

  logic w_sclk_s;
  logic w_cs_s;
  logic w_mosi_s;

  sync_ff #(.DEPTH(SYNC_DEPTH), .RST_VAL(1'b0)) u_sync_sclk (
    .clk     (clk),
    .reset_n (reset_n),
    .i_d     (spi.spi_clk),
    .o_q     (w_sclk_s)
  );

  sync_ff #(.DEPTH(SYNC_DEPTH), .RST_VAL(1'b1)) u_sync_cs (
    .clk     (clk),
    .reset_n (reset_n),
    .i_d     (spi.cs_n),
    .o_q     (w_cs_s)
  );

  sync_ff #(.DEPTH(SYNC_DEPTH), .RST_VAL(1'b0)) u_sync_mosi (
    .clk     (clk),
    .reset_n (reset_n),
    .i_d     (spi.mosi),
    .o_q     (w_mosi_s)
  );

  // Edge detection: one extra register behind each synchronizer.
  logic r_sclk_d;
  logic r_cs_d;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_sclk_d <= 1'b0;
      r_cs_d   <= 1'b1;
    end else begin
      r_sclk_d <= w_sclk_s;
      r_cs_d   <= w_cs_s;
    end
  end

  logic w_sclk_rise;
  logic w_sclk_fall;
  logic w_sample;
  logic w_cs_fall;
  logic w_cs_rise;

  assign w_sclk_rise = w_sclk_s & ~r_sclk_d;
  assign w_sclk_fall = ~w_sclk_s & r_sclk_d;
  assign w_sample    = (SAMPLE_EDGE == EDGE_RISE) ? w_sclk_rise : w_sclk_fall;
  assign w_cs_fall   = ~w_cs_s & r_cs_d;
  assign w_cs_rise   = w_cs_s & ~r_cs_d;

  // The cs_n synchronizer resets to 1, so a cs_n held low across reset
  // release would look like a falling edge. Frames are only accepted once
  // cs_n has been seen high with a settled synchronizer, or has risen.
  logic [SETTLE_W-1:0] r_settle;
  logic                r_armed;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_settle <= '0;
      r_armed  <= 1'b0;
    end else begin
      if (r_settle != SETTLE_DONE) begin
        r_settle <= r_settle + 1'b1;
      end
      if (((r_settle == SETTLE_DONE) && w_cs_s) || w_cs_rise) begin
        r_armed <= 1'b1;
      end
    end
  end

  logic [FRAME_BITS-1:0] r_shift;
  logic [CNT_W-1:0]      r_cnt;
  logic [WIDTH-1:0]      w_payload;
  logic                  w_par_ok;
  logic                  w_frame_ok;

`ifdef SPI2MEM_SLAVE_PARITY_EN
  assign w_payload = r_shift[FRAME_BITS-1:1];
  // Odd parity: payload plus parity bit must hold an odd number of ones.
  assign w_par_ok  = ^r_shift;
`else
  assign w_payload = r_shift;
  assign w_par_ok  = 1'b1;
`endif

  assign w_frame_ok = (r_cnt == CNT_FULL) && w_par_ok;

  state_t           r_state;
  logic [WIDTH-1:0] r_memory;
  logic             r_update;
  logic             r_frame_err;
  logic             r_busy;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_shift     <= '0;
      r_cnt       <= '0;
      r_memory    <= RESET_VALUE;
      r_update    <= 1'b0;
      r_frame_err <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_update    <= 1'b0;
      r_frame_err <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (r_armed && w_cs_fall) begin
            r_state <= ST_SHIFT;
            r_shift <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
          end
        end
        ST_SHIFT: begin
          // cs_n rising wins over a coincident spi_clk edge.
          if (w_cs_rise) begin
            r_state <= ST_CHECK;
            r_busy  <= 1'b0;
          end else if (w_sample) begin
            r_shift <= {r_shift[FRAME_BITS-2:0], w_mosi_s};
            if (r_cnt != CNT_SAT) begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        ST_CHECK: begin
          if (w_frame_ok) begin
            r_memory <= w_payload;
            r_update <= 1'b1;
          end else begin
            r_frame_err <= 1'b1;
          end
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign memory    = r_memory;
  assign update    = r_update;
  assign frame_err = r_frame_err;
  assign busy      = r_busy;

endmodule
